// File: rtl/pattern_buffer_bank_if.sv
// Serial load/readback link of the pattern buffer bank.
//   sclk  - serial shift clock (async to the system clock)
//   sin   - serial data, MSB of the highest word first
//   ssel  - frame select, active-high
//   saddr - target buffer, captured when a frame opens
//   sout  - serial readback, MSB of the shadow chain
// The master modport drives the frame; the slave modport is the bank side.
interface pattern_buffer_bank_if #(
    parameter int unsigned BUFP_W = 3
);
    logic              sclk;
    logic              sin;
    logic              ssel;
    logic [BUFP_W-1:0] saddr;
    logic              sout;

    modport master (output sclk, output sin, output ssel, output saddr, input sout);
    modport slave  (input sclk, input sin, input ssel, input saddr, output sout);
endinterface

// File: rtl/pattern_buffer_bank.sv
// Bank of NUM_BUFS pattern buffers, each BUF_SIZE words of BUF_WIDTH bits.
// Loaded through a serial shadow chain that is oversampled in the clk domain
// and committed as a whole when a complete frame ends. Read out through the
// buffer/field pointers.
//   clk, rst        - system clock, asynchronous active-high reset
//   ser             - serial link (sclk/sin/ssel/saddr in, sout out)
//   bufp_in/fieldp_in, ld_*/inc_* - pointer load and increment controls
//   pattern_out     - registered copy of buffer[bufp]
//   field_byte_out  - registered buffer[bufp][fieldp]
//   load_done       - 1-cycle pulse while a commit is performed
//   load_err        - 1-cycle pulse when a short frame is aborted
module pattern_buffer_bank #(
    parameter int unsigned BUF_WIDTH = 8,
    parameter int unsigned BUF_SIZE  = 32,
    parameter int unsigned NUM_BUFS  = 8,
    parameter int unsigned BUFP_W    = 3,
    parameter int unsigned FIELDP_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    pattern_buffer_bank_if.slave          ser,
    input  logic [BUFP_W-1:0]             bufp_in,
    input  logic [FIELDP_W-1:0]           fieldp_in,
    input  logic                          ld_bufp,
    input  logic                          inc_bufp,
    input  logic                          ld_fieldp,
    input  logic                          inc_fieldp,
    output logic [BUF_SIZE*BUF_WIDTH-1:0] pattern_out,
    output logic [BUF_WIDTH-1:0]          field_byte_out,
    output logic                          load_done,
    output logic                          load_err
);
    localparam int unsigned TOTAL = BUF_SIZE * BUF_WIDTH;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [BUFP_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOTAL-1:0]   shadow_q, shadow_d;
    logic               err_q, err_d;
    logic               commit;

    logic [TOTAL-1:0]   mem_q [NUM_BUFS];
    logic [BUFP_W-1:0]  bufp_q, bufp_d;
    logic [FIELDP_W-1:0] fieldp_q, fieldp_d;
    logic [TOTAL-1:0]   pattern_q;
    logic [BUF_WIDTH-1:0] field_q;

    // Stage [1] is the synchronised value; stage [2] only exists for edge detection.
    logic [2:0] sclk_sync_q;
    logic [1:0] sin_sync_q;
    logic [2:0] ssel_sync_q;

    logic shift_ev, ssel_rise, ssel_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sin_sync_q  <= '0;
            ssel_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], ser.sclk};
            sin_sync_q  <= {sin_sync_q[0], ser.sin};
            ssel_sync_q <= {ssel_sync_q[1:0], ser.ssel};
        end
    end

    assign shift_ev  =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ssel_rise =  ssel_sync_q[1] & ~ssel_sync_q[2];
    assign ssel_fall = ~ssel_sync_q[1] &  ssel_sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        err_d    = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_rise) begin
                    state_d  = SHIFT;
                    target_d = BUFP_W'(ser.saddr % NUM_BUFS);
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                if (shift_ev) begin
                    shadow_d = {shadow_q[TOTAL-2:0], sin_sync_q[1]};
                    // Overlong frames keep shifting but the count stays pinned at full.
                    if (cnt_q != CNT_W'(TOTAL)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (ssel_fall) begin
                    if (cnt_q == CNT_W'(TOTAL)) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BUFS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[target_q] <= shadow_q;
        end
    end

    // A bufp update in a cycle freezes fieldp for that cycle.
    always_comb begin
        bufp_d   = bufp_q;
        fieldp_d = fieldp_q;
        if (ld_bufp) begin
            bufp_d = BUFP_W'(bufp_in % NUM_BUFS);
        end else if (inc_bufp) begin
            bufp_d = (bufp_q == BUFP_W'(NUM_BUFS - 1)) ? '0 : bufp_q + 1'b1;
        end else if (ld_fieldp) begin
            fieldp_d = FIELDP_W'(fieldp_in % BUF_SIZE);
        end else if (inc_fieldp) begin
            fieldp_d = (fieldp_q == FIELDP_W'(BUF_SIZE - 1)) ? '0 : fieldp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufp_q    <= '0;
            fieldp_q  <= '0;
            pattern_q <= '0;
            field_q   <= '0;
        end else begin
            bufp_q    <= bufp_d;
            fieldp_q  <= fieldp_d;
            pattern_q <= mem_q[bufp_q];
            field_q   <= mem_q[bufp_q][fieldp_q*BUF_WIDTH +: BUF_WIDTH];
        end
    end

    assign pattern_out    = pattern_q;
    assign field_byte_out = field_q;
    assign load_done      = (state_q == COMMIT);
    assign load_err       = err_q;
    assign ser.sout       = shadow_q[TOTAL-1];
endmodule
